// File: rtl/testframe_checker.sv
// Receive-side testframe statistics: sequence loss/reorder counting and one-way latency.
// Optional latency datapath enabled by `define TESTFRAME_CHECKER_LATENCY_EN.
module testframe_checker #(
  parameter int unsigned NSEC_PER_SEC = 32'd1000000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        testframe_match,
  input  logic [63:0] sequence_num,
  input  logic [47:0] timestamp_sec,
  input  logic [31:0] timestamp_nsec,
  input  logic [47:0] now_sec,
  input  logic [31:0] now_nsec,
  input  logic        clear,
  output logic [63:0] rx_testframes,
  output logic [63:0] lost_testframes,
  output logic [63:0] ooo_testframes,
  output logic [31:0] latency_last,
  output logic [31:0] latency_min,
  output logic [31:0] latency_max,
  output logic        result_valid
);

  logic        en_q, eof_q;
  logic        sample;
  logic        vld_p1_q, vld_p2_q;
  logic [63:0] seq_p1_q, seq_p2_q;

  logic [63:0] rx_q, rx_d, lost_q, lost_d, ooo_q, ooo_d, exp_q, exp_d;
  logic        armed_q, armed_d, rv_q, rv_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q  <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      en_q  <= en;
      eof_q <= en_q & ~en;
    end
  end

  assign sample = eof_q & testframe_match & ~clear;

  // Stage 1: capture sequence number at the sampling edge
  always_ff @(posedge clk) begin
    if (reset || clear) vld_p1_q <= 1'b0;
    else                vld_p1_q <= sample;
  end

  always_ff @(posedge clk) begin
    if (sample) seq_p1_q <= sequence_num;
  end

  // Stage 2: latency result formed, sequence carried along
  always_ff @(posedge clk) begin
    if (reset || clear) vld_p2_q <= 1'b0;
    else                vld_p2_q <= vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (vld_p1_q) seq_p2_q <= seq_p1_q;
  end

  // Stage 3: statistics update
  always_comb begin
    rx_d    = rx_q;
    lost_d  = lost_q;
    ooo_d   = ooo_q;
    exp_d   = exp_q;
    armed_d = armed_q;
    rv_d    = 1'b0;
    if (clear) begin
      rx_d    = 64'd0;
      lost_d  = 64'd0;
      ooo_d   = 64'd0;
      armed_d = 1'b0;
    end else if (vld_p2_q) begin
      rv_d = 1'b1;
      rx_d = rx_q + 64'd1;
      if (!armed_q) begin
        armed_d = 1'b1;
        exp_d   = seq_p2_q + 64'd1;
      end else if (seq_p2_q == exp_q) begin
        exp_d = seq_p2_q + 64'd1;
      end else if (seq_p2_q > exp_q) begin
        lost_d = lost_q + (seq_p2_q - exp_q);
        exp_d  = seq_p2_q + 64'd1;
      end else begin
        ooo_d = ooo_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q    <= 64'd0;
      lost_q  <= 64'd0;
      ooo_q   <= 64'd0;
      exp_q   <= 64'd0;
      armed_q <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      rx_q    <= rx_d;
      lost_q  <= lost_d;
      ooo_q   <= ooo_d;
      exp_q   <= exp_d;
      armed_q <= armed_d;
      rv_q    <= rv_d;
    end
  end

  assign rx_testframes   = rx_q;
  assign lost_testframes = lost_q;
  assign ooo_testframes  = ooo_q;
  assign result_valid    = rv_q;

`ifdef TESTFRAME_CHECKER_LATENCY_EN
  logic               borrow;
  logic signed [49:0] now_s, ts_s, dsec;
  logic        [31:0] dns;
  logic               neg_p1_q, big_p1_q;
  logic        [2:0]  dsec_p1_q;
  logic        [31:0] dns_p1_q;
  logic        [31:0] lat_p2_q;
  logic        [31:0] last_q, last_d, min_q, min_d, max_q, max_d;

  // dsec is bounded to 0..4 once neg/big are excluded, so only 3 bits reach the multiply
  function automatic logic [31:0] sat_latency(input logic neg, input logic big,
                                              input logic [2:0] ds, input logic [31:0] ns);
    logic [34:0] total;
    total = 35'(ds) * 35'(NSEC_PER_SEC) + 35'(ns);
    if (neg)                         return 32'd0;
    else if (big)                    return 32'hFFFFFFFF;
    else if (total > 35'h0FFFFFFFF)  return 32'hFFFFFFFF;
    else                             return total[31:0];
  endfunction

  always_comb begin
    borrow = now_nsec < timestamp_nsec;
    now_s  = {2'b00, now_sec};
    ts_s   = {2'b00, timestamp_sec};
    dsec   = now_s - ts_s - $signed({49'd0, borrow});
    dns    = now_nsec - timestamp_nsec + (borrow ? NSEC_PER_SEC : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (sample) begin
      neg_p1_q  <= dsec < 50'sd0;
      big_p1_q  <= dsec >= 50'sd5;
      dsec_p1_q <= dsec[2:0];
      dns_p1_q  <= dns;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1_q) lat_p2_q <= sat_latency(neg_p1_q, big_p1_q, dsec_p1_q, dns_p1_q);
  end

  always_comb begin
    last_d = last_q;
    min_d  = min_q;
    max_d  = max_q;
    if (clear) begin
      last_d = 32'd0;
      min_d  = 32'hFFFFFFFF;
      max_d  = 32'd0;
    end else if (vld_p2_q) begin
      last_d = lat_p2_q;
      if (lat_p2_q < min_q) min_d = lat_p2_q;
      if (lat_p2_q > max_q) max_d = lat_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 32'd0;
      min_q  <= 32'hFFFFFFFF;
      max_q  <= 32'd0;
    end else begin
      last_q <= last_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign latency_last = last_q;
  assign latency_min  = min_q;
  assign latency_max  = max_q;
`else
  logic unused_time;
  assign unused_time  = ^{timestamp_sec, timestamp_nsec, now_sec, now_nsec};
  assign latency_last = 32'd0;
  assign latency_min  = 32'd0;
  assign latency_max  = 32'd0;
`endif

endmodule

// File: tb/tb_testframe_checker.sv
// Directed plus randomized bench for testframe_checker against a spec-level reference model.
module tb_testframe_checker;
  localparam longint NS = 64'sd1000000000;

  logic        clk = 1'b0;
  logic        reset, en, testframe_match, clear;
  logic [63:0] sequence_num;
  logic [47:0] timestamp_sec, now_sec;
  logic [31:0] timestamp_nsec, now_nsec;
  logic [63:0] rx_testframes, lost_testframes, ooo_testframes;
  logic [31:0] latency_last, latency_min, latency_max;
  logic        result_valid;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_rx, m_lost, m_ooo, m_exp;
  bit          m_armed;
  logic [31:0] m_last, m_min, m_max;

  testframe_checker dut (
    .clk(clk), .reset(reset), .en(en), .testframe_match(testframe_match),
    .sequence_num(sequence_num), .timestamp_sec(timestamp_sec),
    .timestamp_nsec(timestamp_nsec), .now_sec(now_sec), .now_nsec(now_nsec),
    .clear(clear), .rx_testframes(rx_testframes), .lost_testframes(lost_testframes),
    .ooo_testframes(ooo_testframes), .latency_last(latency_last),
    .latency_min(latency_min), .latency_max(latency_max), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Latency from the arithmetic rules directly, using signed 64-bit integers
  function automatic logic [31:0] model_lat(input longint ts_s, input longint ts_n,
                                            input longint now_s, input longint now_n);
    longint ds, dn, v;
    ds = now_s - ts_s;
    dn = now_n - ts_n;
    if (dn < 0) begin dn += NS; ds -= 1; end
    if (ds < 0) return 32'd0;
    if (ds >= 5) return 32'hFFFFFFFF;
    v = ds * NS + dn;
    if (v > 64'sd4294967295) return 32'hFFFFFFFF;
    return v[31:0];
  endfunction

  task automatic model_clear();
    m_rx = 0; m_lost = 0; m_ooo = 0; m_armed = 0;
    m_last = 0; m_min = 32'hFFFFFFFF; m_max = 0;
  endtask

  task automatic model_accept(input logic [63:0] s, input logic [31:0] lat);
    if (!m_armed) begin m_armed = 1; m_exp = s + 1; end
    else if (s == m_exp) m_exp = s + 1;
    else if (s > m_exp) begin m_lost += s - m_exp; m_exp = s + 1; end
    else m_ooo++;
    m_rx++;
    m_last = lat;
    if (lat < m_min) m_min = lat;
    if (lat > m_max) m_max = lat;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_rx"},   rx_testframes,   m_rx);
    chk({tag, "_lost"}, lost_testframes, m_lost);
    chk({tag, "_ooo"},  ooo_testframes,  m_ooo);
`ifdef TESTFRAME_CHECKER_LATENCY_EN
    chk({tag, "_last"}, 64'(latency_last), 64'(m_last));
    chk({tag, "_min"},  64'(latency_min),  64'(m_min));
    chk({tag, "_max"},  64'(latency_max),  64'(m_max));
`else
    chk({tag, "_last"}, 64'(latency_last), 64'd0);
    chk({tag, "_min"},  64'(latency_min),  64'd0);
    chk({tag, "_max"},  64'(latency_max),  64'd0);
`endif
  endtask

  // mode 0: normal, 1: clear during the eof cycle, 2: reset one edge after sampling
  task automatic frame(input string tag, input bit match, input logic [63:0] s,
                       input longint tss, input longint tsn, input longint nows,
                       input longint nown, input int mode);
    logic rv_seen;
    en = 1;
    repeat (4) @(posedge clk);
    #1;
    en = 0;
    testframe_match = match;
    sequence_num    = s;
    timestamp_sec   = 48'(tss);
    timestamp_nsec  = 32'(tsn);
    now_sec         = 48'(nows);
    now_nsec        = 32'(nown);
    @(posedge clk); #1;
    if (mode == 1) clear = 1;
    @(posedge clk); #1;
    clear = 0;
    testframe_match = 0;
    if (mode == 2) reset = 1;
    rv_seen = result_valid;
    @(posedge clk); #1;
    reset = 0;
    rv_seen |= result_valid;
    chk({tag, "_rv_early"}, 64'(rv_seen), 64'd0);
    if (mode == 1) model_clear();
    else if (mode == 2) begin model_clear(); m_exp = 0; end
    else if (match) model_accept(s, model_lat(tss, tsn, nows, nown));
    @(posedge clk); #1;
    chk({tag, "_rv"}, 64'(result_valid), 64'(match && mode == 0));
    chk_stats(tag);
    @(posedge clk); #1;
    chk({tag, "_rv_end"}, 64'(result_valid), 64'd0);
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    model_clear();
    chk_stats("clr");
  endtask

  initial begin
    logic [63:0] s;
    longint tss, tsn, nows, nown;
    bit match;
    reset = 1; en = 0; testframe_match = 0; clear = 0; sequence_num = 0;
    timestamp_sec = 0; timestamp_nsec = 0; now_sec = 0; now_nsec = 0;
    model_clear();
    m_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rv", 64'(result_valid), 64'd0);
    chk_stats("reset");
    reset = 0;
    @(posedge clk); #1;

    frame("seq5", 1, 64'd5, 100, 1000, 100, 1500, 0);
    frame("seq6", 1, 64'd6, 100, 1000, 100, 1800, 0);
    frame("seq7", 1, 64'd7, 100, 1000, 100, 1300, 0);

    do_clear();
    frame("seq10", 1, 64'd10, 5, 0, 5, 10, 0);
    frame("seq14", 1, 64'd14, 5, 0, 5, 20, 0);
    frame("seq12", 1, 64'd12, 5, 0, 5, 30, 0);

    do_clear();
    frame("seqmax",  1, 64'hFFFF_FFFF_FFFF_FFFF, 7, 0, 7, 40, 0);
    frame("seqwrap", 1, 64'd0, 7, 0, 7, 50, 0);
    frame("nomatch", 0, 64'd99, 7, 0, 7, 60, 0);

    do_clear();
    frame("lat200",  1, 64'd1, 100, 999999900, 101, 100, 0);
    frame("latneg",  1, 64'd2, 200, 500, 200, 100, 0);
    frame("latbig",  1, 64'd3, 200, 0, 206, 0, 0);
    frame("latfour", 1, 64'd4, 300, 100, 304, 999999999, 0);

    frame("clreof", 1, 64'd5, 1, 0, 1, 10, 1);
    frame("seq50",  1, 64'd50, 1, 0, 1, 10, 0);
    frame("rstmid", 1, 64'd51, 1, 0, 1, 10, 2);

    s = 64'd1000;
    for (int i = 0; i < 24; i++) begin
      s     = s + 64'($urandom_range(0, 5)) - 64'd2;
      match = ($urandom_range(0, 9) != 0);
      tss   = longint'($urandom_range(0, 32'h7FFFFFFF));
      nows  = tss + longint'($urandom_range(0, 7)) - 1;
      tsn   = longint'($urandom_range(0, 999999999));
      nown  = longint'($urandom_range(0, 999999999));
      frame($sformatf("rnd%0d", i), match, s, tss, tsn, nows, nown, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
